qam_mod_framer: RTL

//  Transmit-side counterpart of the QAM-16 demodulator chain. Accepts 4-bit payload symbols over a valid/ready

---
 rtl/qam_mod_framer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/qam_mod_framer.sv
// QAM-16 transmit framer: preamble + payload + zero tail, Gray-mapped I/Q, zero-stuffed to SPS samples/symbol.
// Registered outputs; counters always describe the sample currently presented on mod_i/mod_q.
module qam_mod_framer #(
    parameter int MOD_WIDTH    = 12,
    parameter int LEVEL        = 256,
    parameter int SPS          = 8,
    parameter int PREAMBLE_LEN = 16,
    parameter int TAIL_LEN     = 32
) (
    input  logic                        axi_clk,
    input  logic                        axi_rstn,
    input  logic [3:0]                  din,
    input  logic                        din_valid,
    input  logic                        din_last,
    output logic                        din_ready,
    output logic signed [MOD_WIDTH-1:0] mod_i,
    output logic signed [MOD_WIDTH-1:0] mod_q,
    output logic                        mod_valid,
    output logic                        busy,
    output logic                        underrun
);

    localparam int SAMP_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int SYM_W  = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
    localparam int TAIL_W = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SPS - 1);
    localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(PREAMBLE_LEN - 1);
    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_LEN - 1);

    localparam logic signed [MOD_WIDTH-1:0] LVL_P3 = MOD_WIDTH'(3 * LEVEL);
    localparam logic signed [MOD_WIDTH-1:0] LVL_P1 = MOD_WIDTH'(LEVEL);
    localparam logic signed [MOD_WIDTH-1:0] LVL_M1 = MOD_WIDTH'(-LEVEL);
    localparam logic signed [MOD_WIDTH-1:0] LVL_M3 = MOD_WIDTH'(-3 * LEVEL);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, TAIL} state_t;

    state_t                        state_q, state_d;
    logic [SAMP_W-1:0]             samp_cnt_q, samp_cnt_d;
    logic [SYM_W-1:0]              sym_cnt_q, sym_cnt_d;
    logic [TAIL_W-1:0]             tail_cnt_q, tail_cnt_d;
    logic                          last_seen_q, last_seen_d;
    logic                          din_ready_q, din_ready_d;
    logic signed [MOD_WIDTH-1:0]   mod_i_q, mod_i_d;
    logic signed [MOD_WIDTH-1:0]   mod_q_q, mod_q_d;
    logic                          mod_valid_q, mod_valid_d;
    logic                          busy_q, busy_d;
    logic                          underrun_q, underrun_d;
    logic                          take_slot;
    logic                          sym_end;
    logic                          accept;

    assign sym_end = (samp_cnt_q == SAMP_LAST);
    assign accept  = din_valid & din_ready_q;

    function automatic logic signed [MOD_WIDTH-1:0] gray_map(input logic [1:0] bits);
        case (bits)
            2'b00:   gray_map = LVL_M3;
            2'b01:   gray_map = LVL_M1;
            2'b11:   gray_map = LVL_P1;
            default: gray_map = LVL_P3;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        samp_cnt_d  = samp_cnt_q;
        sym_cnt_d   = sym_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        last_seen_d = last_seen_q;
        mod_i_d     = '0;
        mod_q_d     = '0;
        mod_valid_d = 1'b0;
        underrun_d  = 1'b0;
        take_slot   = 1'b0;

        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    state_d     = PREAMBLE;
                    samp_cnt_d  = '0;
                    sym_cnt_d   = '0;
                    tail_cnt_d  = '0;
                    last_seen_d = 1'b0;
                    mod_i_d     = LVL_P3;
                    mod_q_d     = LVL_P3;
                    mod_valid_d = 1'b1;
                end
            end
            PREAMBLE: begin
                mod_valid_d = 1'b1;
                if (!sym_end) begin
                    samp_cnt_d = samp_cnt_q + SAMP_W'(1);
                end else if (sym_cnt_q != SYM_LAST) begin
                    // Next preamble symbol index is sym_cnt_q+1: even -> 1010 (+3), odd -> 0000 (-3)
                    samp_cnt_d = '0;
                    sym_cnt_d  = sym_cnt_q + SYM_W'(1);
                    mod_i_d    = sym_cnt_q[0] ? LVL_P3 : LVL_M3;
                    mod_q_d    = sym_cnt_q[0] ? LVL_P3 : LVL_M3;
                end else begin
                    state_d   = PAYLOAD;
                    take_slot = 1'b1;
                end
            end
            PAYLOAD: begin
                mod_valid_d = 1'b1;
                if (!sym_end) begin
                    samp_cnt_d = samp_cnt_q + SAMP_W'(1);
                end else if (last_seen_q) begin
                    state_d    = TAIL;
                    samp_cnt_d = '0;
                    tail_cnt_d = '0;
                end else begin
                    take_slot = 1'b1;
                end
            end
            TAIL: begin
                if (tail_cnt_q != TAIL_LAST) begin
                    tail_cnt_d  = tail_cnt_q + TAIL_W'(1);
                    mod_valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A payload slot either carries the accepted symbol or becomes a zero symbol with an underrun flag
        if (take_slot) begin
            samp_cnt_d = '0;
            if (accept) begin
                mod_i_d     = gray_map(din[3:2]);
                mod_q_d     = gray_map(din[1:0]);
                last_seen_d = din_last;
            end else begin
                underrun_d = 1'b1;
            end
        end

        din_ready_d = ((state_d == PREAMBLE) && (sym_cnt_d == SYM_LAST) && (samp_cnt_d == SAMP_LAST)) ||
                      ((state_d == PAYLOAD) && (samp_cnt_d == SAMP_LAST) && !last_seen_d);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q     <= IDLE;
            samp_cnt_q  <= '0;
            sym_cnt_q   <= '0;
            tail_cnt_q  <= '0;
            last_seen_q <= 1'b0;
            din_ready_q <= 1'b0;
            mod_i_q     <= '0;
            mod_q_q     <= '0;
            mod_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_cnt_q  <= samp_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            last_seen_q <= last_seen_d;
            din_ready_q <= din_ready_d;
            mod_i_q     <= mod_i_d;
            mod_q_q     <= mod_q_d;
            mod_valid_q <= mod_valid_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
        end
    end

    assign din_ready = din_ready_q;
    assign mod_i     = mod_i_q;
    assign mod_q     = mod_q_q;
    assign mod_valid = mod_valid_q;
    assign busy      = busy_q;
    assign underrun  = underrun_q;

endmodule
